// File: rtl/wave_pkg.sv
// Shared encodings for the XY wave generator.
package wave_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TRI  = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_SQR  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

endpackage

// File: rtl/xy_wave_gen_if.sv
// Configuration offer channel: valid/ready handshake plus the config fields.
interface xy_wave_gen_if
  import wave_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
);

  logic             cfg_valid;
  logic             cfg_ready;
  mode_e            cfg_mode;
  logic [WIDTH-1:0] cfg_step;
  logic [DIV_W-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_yphase;

  modport master (
    output cfg_valid, cfg_mode, cfg_step, cfg_div, cfg_yphase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_step, cfg_div, cfg_yphase,
    output cfg_ready
  );

endinterface

// File: rtl/wave_channel.sv
// One waveform channel: counter, direction bit, step rules and registered DAC mux.
module wave_channel
  import wave_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  mode_e            mode_i,
  input  mode_e            out_mode_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] dac_o,
  output logic             wrap_c_o
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic             up_q, up_d;
  logic [WIDTH:0]   sum_c;
  logic             frozen_c;

  // Frame boundary: triangle/square turn at zero, sawtooth carry-out.
  always_comb begin
    sum_c    = {1'b0, cnt_q} + {1'b0, step_i};
    frozen_c = (mode_i == MODE_HOLD) || (step_i == '0);
    wrap_c_o = 1'b0;
    if (!frozen_c) begin
      if (mode_i == MODE_SAW) begin
        wrap_c_o = sum_c[WIDTH];
      end else begin
        wrap_c_o = !up_q && (cnt_q <= step_i);
      end
    end
  end

  // Next counter state; a load overrides any tick in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    up_d  = up_q;
    if (load_i) begin
      cnt_d = load_val_i;
      up_d  = 1'b1;
    end else if (tick_i && !frozen_c) begin
      if (mode_i == MODE_SAW) begin
        cnt_d = sum_c[WIDTH-1:0];
        up_d  = 1'b1;
      end else if (up_q) begin
        if ((MAX - cnt_q) <= step_i) begin
          cnt_d = MAX;
          up_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + step_i;
        end
      end else begin
        if (cnt_q <= step_i) begin
          cnt_d = '0;
          up_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - step_i;
        end
      end
    end
    dac_d = cnt_d;
    if (out_mode_i == MODE_SQR) begin
      dac_d = up_d ? MAX : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RST_VAL;
      up_q  <= 1'b1;
      dac_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
      up_q  <= up_d;
      dac_q <= dac_d;
    end
  end

  assign dac_o = dac_q;

endmodule

// File: rtl/xy_wave_gen.sv
// XY waveform generator: prescaler, shadow config with handshake, two channels.
module xy_wave_gen
  import wave_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  xy_wave_gen_if.slave     cfg,
  output logic [WIDTH-1:0] xdac,
  output logic [WIDTH-1:0] ydac,
  output logic             frame_start
);

  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

  mode_e            mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic [WIDTH-1:0] step_q, step_d, sh_step_q, sh_step_d;
  logic [DIV_W-1:0] div_q, div_d, sh_div_q, sh_div_d;
  logic [WIDTH-1:0] yph_q, yph_d, sh_yph_q, sh_yph_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             ready_q, ready_d;
  logic             fs_q, fs_d;

  logic tick_c, boundary_c, apply_c, capture_c, x_wrap_c, y_wrap_unused;

  always_comb begin
    tick_c     = enable && (presc_q == div_q);
    boundary_c = tick_c && x_wrap_c;
    capture_c  = cfg.cfg_valid && ready_q;
    // A pending config waits for a frame boundary unless the generator is idle.
    apply_c    = !ready_q &&
                 (boundary_c || (mode_q == MODE_HOLD) || (step_q == '0) || !enable);

    sh_mode_d = sh_mode_q;
    sh_step_d = sh_step_q;
    sh_div_d  = sh_div_q;
    sh_yph_d  = sh_yph_q;
    mode_d    = mode_q;
    step_d    = step_q;
    div_d     = div_q;
    yph_d     = yph_q;
    presc_d   = presc_q;
    ready_d   = ready_q;
    fs_d      = apply_c || boundary_c;

    if (capture_c) begin
      sh_mode_d = cfg.cfg_mode;
      sh_step_d = cfg.cfg_step;
      sh_div_d  = cfg.cfg_div;
      sh_yph_d  = cfg.cfg_yphase;
      ready_d   = 1'b0;
    end

    if (apply_c) begin
      mode_d  = sh_mode_q;
      step_d  = sh_step_q;
      div_d   = sh_div_q;
      yph_d   = sh_yph_q;
      presc_d = '0;
      ready_d = 1'b1;
    end else if (enable) begin
      presc_d = tick_c ? '0 : presc_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_TRI;
      step_q    <= WIDTH'(1);
      div_q     <= '0;
      yph_q     <= MID;
      sh_mode_q <= MODE_TRI;
      sh_step_q <= WIDTH'(1);
      sh_div_q  <= '0;
      sh_yph_q  <= MID;
      presc_q   <= '0;
      ready_q   <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      step_q    <= step_d;
      div_q     <= div_d;
      yph_q     <= yph_d;
      sh_mode_q <= sh_mode_d;
      sh_step_q <= sh_step_d;
      sh_div_q  <= sh_div_d;
      sh_yph_q  <= sh_yph_d;
      presc_q   <= presc_d;
      ready_q   <= ready_d;
      fs_q      <= fs_d;
    end
  end

  wave_channel #(.WIDTH(WIDTH), .RST_VAL('0)) u_x (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (tick_c),
    .load_i     (apply_c),
    .load_val_i ('0),
    .mode_i     (mode_q),
    .out_mode_i (mode_d),
    .step_i     (step_q),
    .dac_o      (xdac),
    .wrap_c_o   (x_wrap_c)
  );

  wave_channel #(.WIDTH(WIDTH), .RST_VAL(MID)) u_y (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (tick_c),
    .load_i     (apply_c),
    .load_val_i (sh_yph_q),
    .mode_i     (mode_q),
    .out_mode_i (mode_d),
    .step_i     (step_q),
    .dac_o      (ydac),
    .wrap_c_o   (y_wrap_unused)
  );

  assign cfg.cfg_ready = ready_q;
  assign frame_start   = fs_q;

endmodule

// File: tb/tb_xy_wave_gen.sv
// Directed self-checking bench for xy_wave_gen (WIDTH=8, DIV_W=8).
module tb_xy_wave_gen;
  import wave_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] xdac, ydac;
  logic             frame_start;

  int n_checks = 0;
  int n_errors = 0;

  xy_wave_gen_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) cfg_if ();

  xy_wave_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg         (cfg_if),
    .xdac        (xdac),
    .ydac        (ydac),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one config for a single edge, starting at a falling edge.
  task automatic offer_cfg(input mode_e m, input logic [7:0] st, input logic [7:0] dv,
                           input logic [7:0] yp);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_mode   = m;
    cfg_if.cfg_step   = st;
    cfg_if.cfg_div    = dv;
    cfg_if.cfg_yphase = yp;
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b0;
  endtask

  initial begin
    int wait_n;
    int exp_x;
    logic [7:0] prev_x;
    int saw_exp [8];
    saw_exp = '{0, 64, 64, 128, 128, 192, 192, 0};

    reset             = 1'b1;
    enable            = 1'b1;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_mode   = MODE_TRI;
    cfg_if.cfg_step   = 8'd0;
    cfg_if.cfg_div    = 8'd0;
    cfg_if.cfg_yphase = 8'd0;

    @(negedge clk);
    check_eq("rst_x", 32'(xdac), 0);
    check_eq("rst_y", 32'(ydac), 128);
    check_eq("rst_ready", 32'(cfg_if.cfg_ready), 1);
    check_eq("rst_fs", 32'(frame_start), 0);
    reset = 1'b0;

    // Default triangle, step 1, tick every cycle.
    for (int k = 1; k <= 511; k++) begin
      @(negedge clk);
      exp_x = (k <= 255) ? k : ((k <= 510) ? 510 - k : k - 510);
      check_eq("def_x", 32'(xdac), 32'(exp_x));
      check_eq("def_fs", 32'(frame_start), (k == 510) ? 1 : 0);
      if (k == 1)   check_eq("def_y1", 32'(ydac), 129);
      if (k == 127) check_eq("def_y127", 32'(ydac), 255);
      if (k == 128) check_eq("def_y128", 32'(ydac), 254);
    end

    // Mid-frame offer, then an offer that must be ignored.
    offer_cfg(MODE_TRI, 8'd16, 8'd0, 8'h40);
    check_eq("mid_ready", 32'(cfg_if.cfg_ready), 0);
    check_eq("mid_x", 32'(xdac), 2);
    offer_cfg(MODE_SAW, 8'd99, 8'd0, 8'h99);
    check_eq("ign_ready", 32'(cfg_if.cfg_ready), 0);
    check_eq("ign_x", 32'(xdac), 3);
    prev_x = xdac;
    for (wait_n = 1; wait_n <= 600; wait_n++) begin
      @(negedge clk);
      if (frame_start) break;
      prev_x = xdac;
    end
    check_eq("apply_wait", 32'(wait_n), 507);
    check_eq("apply_prev_x", 32'(prev_x), 1);
    check_eq("apply_x", 32'(xdac), 0);
    check_eq("apply_y", 32'(ydac), 32'h40);
    check_eq("apply_ready", 32'(cfg_if.cfg_ready), 1);

    // Triangle step 16.
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i <= 15)      exp_x = 16 * i;
      else if (i == 16) exp_x = 255;
      else if (i <= 31) exp_x = 255 - 16 * (i - 16);
      else              exp_x = 0;
      check_eq("tri16_x", 32'(xdac), 32'(exp_x));
      check_eq("tri16_fs", 32'(frame_start), (i == 32) ? 1 : 0);
      if (i == 1) check_eq("tri16_y1", 32'(ydac), 32'h50);
    end

    // Enable low: pending config applies on the first cycle after capture.
    enable = 1'b0;
    offer_cfg(MODE_SAW, 8'd64, 8'd1, 8'h10);
    check_eq("saw_cap_ready", 32'(cfg_if.cfg_ready), 0);
    check_eq("saw_cap_y", 32'(ydac), 32'h40);
    @(negedge clk);
    check_eq("saw_apply_fs", 32'(frame_start), 1);
    check_eq("saw_apply_x", 32'(xdac), 0);
    check_eq("saw_apply_y", 32'(ydac), 32'h10);
    check_eq("saw_apply_ready", 32'(cfg_if.cfg_ready), 1);
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_eq("saw_x", 32'(xdac), 32'(saw_exp[i-1]));
      check_eq("saw_fs", 32'(frame_start), (i == 8) ? 1 : 0);
      if (i == 2) check_eq("saw_y2", 32'(ydac), 32'h50);
      if (i == 8) check_eq("saw_y8", 32'(ydac), 32'h10);
    end

    // Freeze while enable is low.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("frz_x", 32'(xdac), 0);
    check_eq("frz_y", 32'(ydac), 32'h10);
    enable = 1'b1;
    @(negedge clk);
    check_eq("frz_rel_x0", 32'(xdac), 0);
    @(negedge clk);
    check_eq("frz_rel_x1", 32'(xdac), 64);

    // Reset between edges with a config pending.
    offer_cfg(MODE_TRI, 8'd3, 8'd0, 8'h22);
    check_eq("pre_rst_ready", 32'(cfg_if.cfg_ready), 0);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_x", 32'(xdac), 0);
    check_eq("arst_y", 32'(ydac), 128);
    check_eq("arst_ready", 32'(cfg_if.cfg_ready), 1);
    check_eq("arst_fs", 32'(frame_start), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_x", 32'(xdac), 1);
    check_eq("post_rst_y", 32'(ydac), 129);
    repeat (5) @(negedge clk);
    check_eq("post_rst_x6", 32'(xdac), 6);
    check_eq("post_rst_ready", 32'(cfg_if.cfg_ready), 1);

    // Square step 1.
    enable = 1'b0;
    offer_cfg(MODE_SQR, 8'd1, 8'd0, 8'h80);
    @(negedge clk);
    check_eq("sqr_apply_fs", 32'(frame_start), 1);
    check_eq("sqr_apply_x", 32'(xdac), 255);
    enable = 1'b1;
    for (int i = 1; i <= 510; i++) begin
      @(negedge clk);
      exp_x = (i <= 254 || i == 510) ? 255 : 0;
      check_eq("sqr_x", 32'(xdac), 32'(exp_x));
      if (i == 255) check_eq("sqr_fs_mid", 32'(frame_start), 0);
      if (i == 510) check_eq("sqr_fs_end", 32'(frame_start), 1);
    end

    // Hold: frozen outputs, and a new config applies immediately.
    enable = 1'b0;
    offer_cfg(MODE_HOLD, 8'd5, 8'd0, 8'd7);
    @(negedge clk);
    check_eq("hold_apply_fs", 32'(frame_start), 1);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("hold_x", 32'(xdac), 0);
    check_eq("hold_y", 32'(ydac), 7);
    check_eq("hold_fs", 32'(frame_start), 0);
    offer_cfg(MODE_TRI, 8'd2, 8'd0, 8'd0);
    check_eq("hold_cap_ready", 32'(cfg_if.cfg_ready), 0);
    check_eq("hold_cap_x", 32'(xdac), 0);
    @(negedge clk);
    check_eq("hold_exit_fs", 32'(frame_start), 1);
    check_eq("hold_exit_ready", 32'(cfg_if.cfg_ready), 1);
    check_eq("hold_exit_y", 32'(ydac), 0);
    @(negedge clk);
    check_eq("tri2_x", 32'(xdac), 2);
    check_eq("tri2_y", 32'(ydac), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/xy_wave_gen.md
XY_WAVE_GEN -- requirements
Module: xy_wave_gen

Interface
REQ-001 Parameter WIDTH, default 8: DAC sample width; MAX = 2^WIDTH-1.
REQ-002 Parameter DIV_W, default 8: prescaler divider width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high = generator advances; low = prescaler and both channels freeze.
REQ-006 cfg_valid  input  1  config offer; cfg_* fields are valid while high.
REQ-007 cfg_ready  output  1  high when the shadow config register is empty.
REQ-008 cfg_mode  input  2  0 triangle, 1 sawtooth, 2 square, 3 hold.
REQ-009 cfg_step  input  WIDTH  counter increment per tick.
REQ-010 cfg_div  input  DIV_W  tick every cfg_div+1 enabled cycles.
REQ-011 cfg_yphase  input  WIDTH  Y counter start value.
REQ-012 xdac  output  WIDTH  X sample, registered.
REQ-013 ydac  output  WIDTH  Y sample, registered.
REQ-014 frame_start  output  1  one-cycle pulse at each X frame boundary and on each config apply.

Function
REQ-015 Prescaler SHALL count 0..div_act; tick SHALL assert in the cycle it equals div_act with enable high, then wrap to 0; div_act=0 gives a tick every enabled cycle.
REQ-016 Each channel SHALL hold counter cnt and direction bit up; both SHALL update only on tick.
REQ-017 Triangle, up: if MAX-cnt <= step then cnt<=MAX, up<=0, else cnt<=cnt+step.
REQ-018 Triangle, down: if cnt <= step then cnt<=0, up<=1, else cnt<=cnt-step; MAX and 0 SHALL each appear exactly once per turn.
REQ-019 Sawtooth: cnt<=(cnt+step) mod 2^WIDTH; up stays 1.
REQ-020 Square: cnt SHALL run as triangle; dac output SHALL be MAX while up=1, else 0.
REQ-021 Hold, or step=0: cnt and up SHALL be frozen.
REQ-022 X frame boundary: triangle/square tick where X turns at 0 (down to up); sawtooth tick where cnt+step carries out of WIDTH bits.
REQ-023 Handshake: cfg_valid && cfg_ready SHALL capture cfg_* into the shadow, set pending, and drive cfg_ready low from the next cycle.
REQ-024 cfg_valid while cfg_ready is low SHALL be ignored; the shadow SHALL NOT change.
REQ-025 A pending config SHALL apply at the next X frame-boundary tick; it SHALL apply on the first cycle after capture if the active mode is hold, the active step is 0, or enable is low.
REQ-026 Apply SHALL: load active regs from the shadow; set X cnt=0, up=1; set Y cnt=yphase, up=1; set prescaler=0; clear pending; pulse frame_start. cfg_ready SHALL be high the following cycle.
REQ-027 If apply coincides with a tick, the apply values SHALL win; no step SHALL be taken that cycle.
REQ-028 Y SHALL use the same mode, step and tick as X; Y has no frame boundary.

Reset
REQ-029 Reset SHALL immediately force: mode=triangle, step=1, div=0, yphase=2^(WIDTH-1), X cnt=0, Y cnt=2^(WIDTH-1), both up=1, prescaler=0, pending=0, frame_start=0, cfg_ready=1, xdac=0, ydac=2^(WIDTH-1).
REQ-030 Reset asserted mid-frame or while a config is pending SHALL discard the pending config.

Structure
REQ-031 Mode encodings (TRI, SAW, SQR, HOLD) SHALL live in a shared package wave_pkg.
REQ-032 One sub-module wave_channel (cnt, up, step logic, output mux) SHALL be instantiated twice; the prescaler, shadow register and handshake stay in the top.

Verification (WIDTH=8)
REQ-033 Reset, enable=1, defaults -> X 0,1..255,254..0; Y starts 128 and rises; frame_start pulses at cycle 510 after reset release.
REQ-034 Triangle step=16 -> X 0,16..240,255,239..15,0; one frame_start per return to 0.
REQ-035 Sawtooth step=64, div=1 -> X holds each value 2 cycles: 0,64,128,192,0; frame_start on the wrap tick.
REQ-036 Config offered mid-frame -> cfg_ready low next cycle; outputs unchanged until the X boundary; then X=0, Y=yphase, frame_start=1.
REQ-037 Square step=1 -> xdac=255 for 255 ticks, then 0 for 255 ticks.
REQ-038 Reset pulsed between clock edges mid-sawtooth -> xdac=0, ydac=128, cfg_ready=1 before the next edge.
